// File: rtl/rv32_data_mem_responder_pkg.sv
// rv32_data_mem_responder_pkg: data-port request/response types, op encodings and responder FSM states
package rv32_data_mem_responder_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_op_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        mem_op_t     op;
        logic [3:0]  strobe;
    } memory_request_t;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } memory_response_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_resp_state_t;

    // unsigned window test done without wrap-around: offset only meaningful once addr >= base
    function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] base, input logic [32:0] span);
        return (addr >= base) && ({1'b0, addr - base} < span);
    endfunction

endpackage

// File: rtl/rv32_byte_ram.sv
// rv32_byte_ram: single-port synchronous word RAM with per-byte write enables, read-first
module rv32_byte_ram #(
    parameter int WORDS = 4096,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    // registered read returns the old word when a write hits the same address on the same edge
    always_ff @(posedge clk) begin
        rdata <= mem[addr];
        for (int i = 0; i < 4; i++)
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end

endmodule

// File: rtl/rv32_data_mem_responder.sv
// rv32_data_mem_responder: data-port responder with programmable wait, byte-masked writes and sticky range fault
module rv32_data_mem_responder
    import rv32_data_mem_responder_pkg::*;
#(
    parameter int          MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LATENCY   = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  memory_request_t  data_request,
    output memory_response_t data_response,
    output logic             access_fault
);

    localparam int          AW   = $clog2(MEM_WORDS);
    localparam int          CW   = LATENCY > 1 ? $clog2(LATENCY) : 1;
    localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;

    mem_resp_state_t state;
    memory_request_t req;
    logic [CW-1:0]   counter;
    logic [AW-1:0]   ram_addr;
    logic [31:0]     rdata;
    logic [3:0]      we;
    logic            in_range;
    logic            resp_active;

    assign in_range    = addr_in_range(req.addr, BASE_ADDR, SPAN);
    assign resp_active = (state == RESP) && resetn;
    // IDLE reads from the live address so a single-cycle latency still has data in RESP
    assign ram_addr    = AW'(((state == IDLE ? data_request.addr : req.addr) - BASE_ADDR) >> 2);
    assign we          = (resp_active && req.op == MEM_WRITE && in_range) ? req.strobe : 4'b0000;

    rv32_byte_ram #(.WORDS(MEM_WORDS), .AW(AW)) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (we),
        .wdata (req.data),
        .rdata (rdata)
    );

    // ready never stalls non-memory ops; read data is only exposed during a valid RESP
    always_comb begin
        data_response.ready = (data_request.op == MEM_NONE) || resp_active;
        data_response.data  = (resp_active && req.op == MEM_READ && in_range) ? rdata : 32'h0;
    end

    // capture one request, count down the wait, then hold RESP for exactly one cycle
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            counter      <= '0;
            access_fault <= 1'b0;
            req          <= '0;
        end else begin
            case (state)
                IDLE: if (data_request.op != MEM_NONE) begin
                    req          <= data_request;
                    counter      <= CW'(LATENCY - 1);
                    state        <= (LATENCY == 1) ? RESP : WAIT;
                    access_fault <= access_fault | !addr_in_range(data_request.addr, BASE_ADDR, SPAN);
                end
                WAIT: begin
                    counter <= counter - CW'(1);
                    state   <= (counter == CW'(1)) ? RESP : WAIT;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
